// File: rtl/instr_fetch_reader.sv
// ============================================================================
//  Module      : instr_fetch_reader
//  Description : Read-side fetch sequencer. It reads a data byte or a two-byte
//                instruction from synchronous memory and returns a decoded response.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_reader #(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_kind,
   input  logic [12:0] req_addr,
   output logic        mem_rd,
   output logic [12:0] mem_addr,
   input  logic [7:0]  mem_rdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_kind,
   output logic [7:0]  rsp_data,
   output logic [2:0]  rsp_opcode,
   output logic [12:0] rsp_addr
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_HI   = 3'd1,
      S_WAIT_HI = 3'd2,
      S_RD_LO   = 3'd3,
      S_WAIT_LO = 3'd4,
      S_RESP    = 3'd5
   } state_t;

   // Last wait cycle index; the byte is captured on the edge that ends it.
   localparam logic [1:0] c_lat_last = 2'(MEM_LAT - 1);

   state_t      r_state;
   logic [12:0] r_addr;
   logic        r_kind;
   logic [7:0]  r_hi;
   logic [1:0]  r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_addr     <= 13'd0;
         r_kind     <= 1'b0;
         r_hi       <= 8'd0;
         r_cnt      <= 2'd0;
         req_ready  <= 1'b1;
         mem_rd     <= 1'b0;
         mem_addr   <= 13'd0;
         rsp_valid  <= 1'b0;
         rsp_kind   <= 1'b0;
         rsp_data   <= 8'd0;
         rsp_opcode <= 3'd0;
         rsp_addr   <= 13'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  r_addr    <= req_addr;
                  r_kind    <= req_kind;
                  req_ready <= 1'b0;
                  mem_rd    <= 1'b1;
                  mem_addr  <= req_addr;
                  r_state   <= S_RD_HI;
               end
            end
            S_RD_HI: begin
               mem_rd  <= 1'b0;
               r_cnt   <= 2'd0;
               r_state <= S_WAIT_HI;
            end
            S_WAIT_HI: begin
               if (r_cnt == c_lat_last) begin
                  r_hi <= mem_rdata;
                  if (r_kind) begin
                     mem_rd   <= 1'b1;
                     mem_addr <= r_addr + 13'd1;
                     r_state  <= S_RD_LO;
                  end else begin
                     rsp_valid  <= 1'b1;
                     rsp_kind   <= 1'b0;
                     rsp_data   <= mem_rdata;
                     rsp_opcode <= 3'd0;
                     rsp_addr   <= r_addr;
                     r_state    <= S_RESP;
                  end
               end else begin
                  r_cnt <= r_cnt + 2'd1;
               end
            end
            S_RD_LO: begin
               mem_rd  <= 1'b0;
               r_cnt   <= 2'd0;
               r_state <= S_WAIT_LO;
            end
            S_WAIT_LO: begin
               if (r_cnt == c_lat_last) begin
                  rsp_valid  <= 1'b1;
                  rsp_kind   <= 1'b1;
                  rsp_data   <= r_hi;
                  rsp_opcode <= r_hi[7:5];
                  rsp_addr   <= {r_hi[4:0], mem_rdata};
                  r_state    <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 2'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               req_ready <= 1'b1;
               mem_rd    <= 1'b0;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
